mult_share_arbiter: RTL and testbench

- Shares one 16x16 unsigned combinational multiplier (the team's Wallace-tree multiplier) among NREQ requesters.
- Sequences each operation through the multiplier:
  - round-robin grant;
  - operand registration;
  - latency countdown;
  - result capture;
  - response handshake.
- Sits between client blocks and the multiplier instance. Only one operation is in flight at a time.

---
 rtl/mult_share_arbiter.sv | 110 +++++++++++
 tb/tb_mult_share_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 16x16 unsigned multiplier among NREQ requesters
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   req_valid/ready    per-requester handshake; req_ready is one-hot or zero, only in IDLE
//   req_a, req_b       packed 16-bit operands, requester i at [16i+15:16i]
//   mul_a, mul_b       registered operands driving the shared multiplier
//   mul_result         multiplier product, valid MUL_LAT cycles after mul_a/mul_b load
//   rsp_valid/ready    response handshake carrying rsp_data (product) and rsp_id (owner)
//   busy               high whenever an operation is in flight or awaiting handshake
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (MUL_LAT < 1) begin : g_lat_chk
        $error("mult_share_arbiter: MUL_LAT must be >= 1");
    end
    if ((2 ** IDW) < NREQ) begin : g_idw_chk
        $error("mult_share_arbiter: IDW too narrow for NREQ");
    end

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_last;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_mul_a;
    logic [15:0]     r_mul_b;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;
    logic            w_found;
    logic [IDW-1:0]  w_gidx;

    // first valid requester strictly after the last grant, wrapping to 0
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (int'(r_last) + k) % NREQ;
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(j);
            end
        end
    end

    assign req_ready = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_gidx) : '0;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_mul_a  <= req_a[16*w_gidx +: 16];
                    r_mul_b  <= req_b[16*w_gidx +: 16];
                    r_rsp_id <= w_gidx;
                    r_last   <= w_gidx;
                    r_cnt    <= CW'(MUL_LAT - 1);
                    r_state  <= S_CALC;
                end
                S_CALC: if (r_cnt == '0) begin
                    r_rsp_data  <= mul_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scoreboard bench driving a MUL_LAT=1 and a MUL_LAT=3 instance with shared stimulus
module tb_mult_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    p;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [16*NREQ-1:0] req_a = '0;
    logic [16*NREQ-1:0] req_b = '0;
    logic               rsp_ready = 1'b0;

    logic [NREQ-1:0] rdy [2];
    logic [15:0]     ma [2];
    logic [15:0]     mb [2];
    logic [31:0]     mres [2];
    logic            rv [2];
    logic [31:0]     rd [2];
    logic [IDW-1:0]  rid [2];
    logic            bsy [2];
    logic [31:0]     pipe1, pipe2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(NREQ), .MUL_LAT(1), .IDW(IDW)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_a(req_a), .req_b(req_b), .mul_a(ma[0]), .mul_b(mb[0]),
        .mul_result(mres[0]), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
        .rsp_data(rd[0]), .rsp_id(rid[0]), .busy(bsy[0])
    );

    mult_share_arbiter #(.NREQ(NREQ), .MUL_LAT(3), .IDW(IDW)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_a(req_a), .req_b(req_b), .mul_a(ma[1]), .mul_b(mb[1]),
        .mul_result(mres[1]), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
        .rsp_data(rd[1]), .rsp_id(rid[1]), .busy(bsy[1])
    );

    // combinational multiplier for the first instance, 3-cycle pipelined one for the second
    assign mres[0] = 32'(ma[0]) * 32'(mb[0]);
    always @(posedge clk) begin
        pipe1 <= 32'(ma[1]) * 32'(mb[1]);
        pipe2 <= pipe1;
    end
    assign mres[1] = pipe2;

    function automatic void chk(input string n, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] t=%0t: got 0x%0h expected 0x%0h", n, k, $time, act, exp);
        end
    endfunction

    // reference model: phase 0 idle, 1 computing, 2 holding response
    exp_t           sb [2][$];
    int             m_ph [2];
    int             m_cnt [2];
    int             m_last [2];
    logic [15:0]    m_a [2];
    logic [15:0]    m_b [2];
    logic [31:0]    m_p [2];
    logic [31:0]    m_rd [2];
    logic [IDW-1:0] m_rid [2];
    int             g, j, lat;
    logic [NREQ-1:0] er;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 3;
            if (rst) begin
                m_ph[k] = 0; m_last[k] = NREQ - 1; m_a[k] = '0; m_b[k] = '0;
                m_rd[k] = '0; m_rid[k] = '0;
                sb[k].delete();
            end else begin
                g = -1;
                if (m_ph[k] == 0)
                    for (int s = 1; s <= NREQ; s++) begin
                        j = (m_last[k] + s) % NREQ;
                        if (g < 0 && req_valid[j]) g = j;
                    end
                er = (g >= 0) ? (NREQ'(1) << g) : '0;
                chk("req_ready", k, 64'(rdy[k]), 64'(er));
                chk("busy", k, 64'(bsy[k]), 64'(m_ph[k] != 0));
                chk("rsp_valid", k, 64'(rv[k]), 64'(m_ph[k] == 2));
                chk("mul_a", k, 64'(ma[k]), 64'(m_a[k]));
                chk("mul_b", k, 64'(mb[k]), 64'(m_b[k]));
                chk("rsp_data", k, 64'(rd[k]), 64'(m_rd[k]));
                chk("rsp_id", k, 64'(rid[k]), 64'(m_rid[k]));
                if (g >= 0) begin
                    m_a[k]   = req_a[16*g +: 16];
                    m_b[k]   = req_b[16*g +: 16];
                    m_p[k]   = 32'(m_a[k]) * 32'(m_b[k]);
                    m_rid[k] = IDW'(g);
                    m_last[k] = g;
                    sb[k].push_back('{id: IDW'(g), p: m_p[k]});
                    m_ph[k]  = 1;
                    m_cnt[k] = lat;
                end else if (m_ph[k] == 1) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_ph[k] = 2;
                        m_rd[k] = m_p[k];
                    end
                end else if (m_ph[k] == 2 && rsp_ready) begin
                    m_ph[k] = 0;
                end
            end
        end
    end

    // monitor: pops the scoreboard on each response handshake and checks stall stability
    logic           stall [2];
    logic [31:0]    hd [2];
    logic [IDW-1:0] hi [2];
    exp_t           e;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                stall[k] = 1'b0;
            end else begin
                if (stall[k]) begin
                    chk("hold_data", k, 64'(rd[k]), 64'(hd[k]));
                    chk("hold_id", k, 64'(rid[k]), 64'(hi[k]));
                end
                if (rv[k] && rsp_ready) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected[inst%0d] t=%0t: got data 0x%0h expected no response", k, $time, rd[k]);
                    end else begin
                        e = sb[k].pop_front();
                        chk("sb_data", k, 64'(rd[k]), 64'(e.p));
                        chk("sb_id", k, 64'(rid[k]), 64'(e.id));
                    end
                end
                stall[k] = rv[k] && !rsp_ready;
                hd[k] = rd[k];
                hi[k] = rid[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] dir_a [3] = '{16'h1234, 16'hFFFF, 16'h0000};
    logic [15:0] dir_b [3] = '{16'h5678, 16'hFFFF, 16'hBEEF};
    int mode;

    initial begin
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a[15:0] = dir_a[i];
            req_b[15:0] = dir_b[i];
            req_valid = 4'b0001;
            step();
            req_valid = '0;
            repeat (8) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'(i + 1);
            req_b[16*i +: 16] = 16'd2;
        end
        req_valid = '1;
        repeat (25) step();
        req_valid = '0;
        repeat (8) step();
        req_a[15:0] = 16'd7;
        req_b[15:0] = 16'd9;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b0010;
        repeat (9) step();
        rsp_ready = 1'b1;
        repeat (10) step();
        req_valid = '0;
        repeat (8) step();
        req_a[15:0] = 16'h55AA;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1100;
        step();
        req_valid = '0;
        repeat (8) step();
        repeat (3000) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                mode = $urandom_range(0, 7);
                req_a[16*i +: 16] = (mode == 0) ? 16'hFFFF : (mode == 1) ? 16'h0000 : 16'($urandom);
                mode = $urandom_range(0, 7);
                req_b[16*i +: 16] = (mode == 0) ? 16'hFFFF : (mode == 1) ? 16'h0000 : 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
